// File: rtl/wb_commit.sv
// wb_commit: write-side driver for the 32x32 register file.
// Merges single-cycle ALU results with queued, extended load responses into one registered
// write port. The ALU always wins the port, and writes to x0 are suppressed.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a pending write can be
// forwarded to the two read indices.
module wb_commit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [AW-1:0]             alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [AW-1:0]             ld_rd,
    input  logic [2:0]                ld_funct3,
    input  logic [1:0]                ld_addr_lo,
    input  logic [XLEN-1:0]           ld_data,
    output logic [AW-1:0]             oprd,
    output logic [XLEN-1:0]           wrt_data,
    output logic                      wrt_en,
    output logic [$clog2(LQ_DEPTH):0] lq_count,
    input  logic [AW-1:0]             oprs1,
    input  logic [AW-1:0]             oprs2,
    output logic                      byp1_hit,
    output logic                      byp2_hit,
    output logic [XLEN-1:0]           byp1_data,
    output logic [XLEN-1:0]           byp2_data
);

    localparam int unsigned PW = $clog2(LQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(LQ_DEPTH);

    // Queue storage; r_q_kill marks entries overtaken by a younger ALU write to the same rd
    logic [AW-1:0]   r_q_rd   [LQ_DEPTH];
    logic [XLEN-1:0] r_q_data [LQ_DEPTH];
    logic            r_q_kill [LQ_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_ld_ready;
    logic [AW-1:0]   r_oprd;
    logic [XLEN-1:0] r_wrt_data;
    logic            r_wrt_en;

    logic            w_push;
    logic            w_pop;
    logic            w_kill_en;
    logic [CW-1:0]   w_count_d;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ld_ext;

    assign w_push    = ld_valid & r_ld_ready;
    assign w_pop     = ~alu_valid & (r_count != '0);
    assign w_kill_en = alu_valid & (alu_rd != '0);

    // Load extension is applied at enqueue so the queue holds final write data
    always_comb begin
        w_byte   = ld_data[7:0];
        w_half   = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        w_ld_ext = ld_data;
        case (ld_addr_lo)
            2'd0:    w_byte = ld_data[7:0];
            2'd1:    w_byte = ld_data[15:8];
            2'd2:    w_byte = ld_data[23:16];
            default: w_byte = ld_data[31:24];
        endcase
        case (ld_funct3)
            3'b000:  w_ld_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_ld_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_ld_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld_ext = ld_data;
        endcase
    end

    // Occupancy next state; push and pop together leave the count unchanged
    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Queue pointers, entries and kill marking; ld_ready is a registered view of occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ld_ready <= 1'b0;
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                r_q_rd[i]   <= '0;
                r_q_data[i] <= '0;
                r_q_kill[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                if (w_kill_en && (r_q_rd[i] == alu_rd)) begin
                    r_q_kill[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_q_rd[r_wptr]   <= ld_rd;
                r_q_data[r_wptr] <= w_ld_ext;
                // A same-cycle ALU write to this rd is younger than the incoming load
                r_q_kill[r_wptr] <= w_kill_en && (ld_rd == alu_rd);
                r_wptr           <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count    <= w_count_d;
            r_ld_ready <= (w_count_d < DepthC);
        end
    end

    // Registered write port: the ALU result has priority, otherwise the queue head is popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oprd     <= '0;
            r_wrt_data <= '0;
            r_wrt_en   <= 1'b0;
        end else if (alu_valid) begin
            r_oprd     <= alu_rd;
            r_wrt_data <= alu_data;
            r_wrt_en   <= (alu_rd != '0);
        end else if (r_count != '0) begin
            r_oprd     <= r_q_rd[r_rptr];
            r_wrt_data <= r_q_data[r_rptr];
            r_wrt_en   <= ~r_q_kill[r_rptr] & (r_q_rd[r_rptr] != '0);
        end else begin
            r_wrt_en   <= 1'b0;
        end
    end

    assign oprd     = r_oprd;
    assign wrt_data = r_wrt_data;
    assign wrt_en   = r_wrt_en;
    assign lq_count = r_count;
    assign ld_ready = r_ld_ready;

`ifdef WB_BYPASS_EN
    // Forward the write being driven this cycle, which is not yet visible in the register file
    assign byp1_hit  = r_wrt_en & (r_oprd == oprs1) & (oprs1 != '0);
    assign byp2_hit  = r_wrt_en & (r_oprd == oprs2) & (oprs2 != '0);
    assign byp1_data = byp1_hit ? r_wrt_data : '0;
    assign byp2_data = byp2_hit ? r_wrt_data : '0;
`else
    logic w_unused_oprs;
    assign w_unused_oprs = ^{oprs1, oprs2};
    assign byp1_hit  = 1'b0;
    assign byp2_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed literal cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_wb_commit;

    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam int LQ_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [AW-1:0]     alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [AW-1:0]     ld_rd;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_addr_lo;
    logic [XLEN-1:0]   ld_data;
    logic [AW-1:0]     oprd;
    logic [XLEN-1:0]   wrt_data;
    logic              wrt_en;
    logic [$clog2(LQ_DEPTH):0] lq_count;
    logic [AW-1:0]     oprs1;
    logic [AW-1:0]     oprs2;
    logic              byp1_hit;
    logic              byp2_hit;
    logic [XLEN-1:0]   byp1_data;
    logic [XLEN-1:0]   byp2_data;

    wb_commit #(.XLEN(XLEN), .AW(AW), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_data(ld_data),
        .oprd(oprd), .wrt_data(wrt_data), .wrt_en(wrt_en), .lq_count(lq_count),
        .oprs1(oprs1), .oprs2(oprs2),
        .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        bit              killed;
    } ent_t;

    ent_t            mq[$];
    logic [AW-1:0]   m_oprd;
    logic [XLEN-1:0] m_data;
    bit              m_en;
    bit              m_ready;
    int              checks = 0;
    int              errors = 0;
    bit              cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension rules written as shift/sign arithmetic on the whole word
    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
        int bsh;
        int hsh;
        bsh = 8 * int'(lo);
        hsh = 16 * int'(lo[1]);
        case (f3)
            3'b000:  return 32'($signed(w << (24 - bsh)) >>> 24);
            3'b001:  return 32'($signed(w << (16 - hsh)) >>> 16);
            3'b100:  return (w >> bsh) & 32'h0000_00FF;
            3'b101:  return (w >> hsh) & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_oprd  = '0;
        m_data  = '0;
        m_en    = 1'b0;
        m_ready = 1'b0;
    endtask

    // One clock edge of the model, using the inputs held across that edge
    task automatic model_step();
        ent_t e;
        ent_t head;
        bit   pop;
        if (rst) begin
            model_clear();
            return;
        end
        pop = !alu_valid && (mq.size() > 0);
        if (pop) head = mq.pop_front();
        if (ld_valid && m_ready) begin
            e.rd     = ld_rd;
            e.data   = ref_ext(ld_funct3, ld_addr_lo, ld_data);
            e.killed = 1'b0;
            mq.push_back(e);
        end
        if (alu_valid && alu_rd != 0) begin
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].killed = 1'b1;
        end
        if (alu_valid) begin
            m_oprd = alu_rd;
            m_data = alu_data;
            m_en   = (alu_rd != 0);
        end else if (pop) begin
            m_oprd = head.rd;
            m_data = head.data;
            m_en   = !head.killed && (head.rd != 0);
        end else begin
            m_en = 1'b0;
        end
        m_ready = (mq.size() < LQ_DEPTH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            logic e1;
            logic e2;
            chk("oprd", 32'(oprd), 32'(m_oprd));
            chk("wrt_data", wrt_data, m_data);
            chk("wrt_en", 32'(wrt_en), 32'(m_en));
            chk("lq_count", 32'(lq_count), 32'(mq.size()));
            chk("ld_ready", 32'(ld_ready), 32'(m_ready));
`ifdef WB_BYPASS_EN
            e1 = m_en && (m_oprd == oprs1) && (oprs1 != 0);
            e2 = m_en && (m_oprd == oprs2) && (oprs2 != 0);
`else
            e1 = 1'b0;
            e2 = 1'b0;
`endif
            chk("byp1_hit", 32'(byp1_hit), 32'(e1));
            chk("byp2_hit", 32'(byp2_hit), 32'(e2));
            chk("byp1_data", byp1_data, e1 ? m_data : 32'h0);
            chk("byp2_data", byp2_data, e2 ? m_data : 32'h0);
        end
    end

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va;
        logic [31:0] vb;
        rst = 1'b1;
        idle_inputs();
        oprs1 = '0;
        oprs2 = '0;
        model_clear();
        cmp_on = 1'b1;
        tick();
        tick();
        chk("reset_ld_ready", 32'(ld_ready), 32'd0);
        chk("reset_wrt_en", 32'(wrt_en), 32'd0);
        chk("reset_lq_count", 32'(lq_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 32'(ld_ready), 32'd1);

        // ALU result appears one cycle later, then the port goes idle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        alu_valid = 1'b0;
        chk("alu_oprd", 32'(oprd), 32'd5);
        chk("alu_data", wrt_data, 32'h1234);
        chk("alu_en", 32'(wrt_en), 32'd1);
        tick();
        chk("alu_en_drop", 32'(wrt_en), 32'd0);

        // LB then LBU of byte 1 of 0x000080FF
        ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b000; ld_addr_lo = 2'd1;
        ld_data = 32'h0000_80FF;
        tick();
        ld_valid = 1'b0;
        tick();
        chk("lb_data", wrt_data, 32'hFFFF_FF80);
        chk("lb_oprd", 32'(oprd), 32'd3);
        chk("lb_en", 32'(wrt_en), 32'd1);
        ld_valid = 1'b1; ld_funct3 = 3'b100;
        tick();
        ld_valid = 1'b0;
        tick();
        chk("lbu_data", wrt_data, 32'h0000_0080);

        // Two loads queued behind a 3-cycle ALU burst commit afterwards, in order
        va = 32'hA5A5_0001;
        vb = 32'h5A5A_0002;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_0A0A;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_data = va;
        tick();
        ld_rd = 5'd2; ld_data = vb;
        tick();
        ld_valid = 1'b0;
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_count", 32'(lq_count), 32'd2);
        tick();
        chk("burst_alu_oprd", 32'(oprd), 32'd10);
        alu_valid = 1'b0;
        tick();
        chk("drain1_oprd", 32'(oprd), 32'd1);
        chk("drain1_data", wrt_data, va);
        tick();
        chk("drain2_oprd", 32'(oprd), 32'd2);
        chk("drain2_data", wrt_data, vb);
        chk("drain_count", 32'(lq_count), 32'd0);

        // Queued load to x7 is overtaken by an ALU write to x7
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_data = 32'h77;
        tick();
        ld_valid = 1'b0;
        alu_rd = 5'd7; alu_data = 32'hAAAA;
        tick();
        alu_valid = 1'b0;
        chk("kill_alu_data", wrt_data, 32'hAAAA);
        chk("kill_alu_en", 32'(wrt_en), 32'd1);
        tick();
        chk("killed_en", 32'(wrt_en), 32'd0);
        chk("killed_data", wrt_data, 32'h77);

        // ALU write to x0 is suppressed
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        tick();
        alu_valid = 1'b0;
        chk("x0_en", 32'(wrt_en), 32'd0);
        chk("x0_data", wrt_data, 32'hDEAD);

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE_0009;
        tick();
        alu_valid = 1'b0;
        oprs1 = 5'd9;
        #1;
        chk("byp_hit", 32'(byp1_hit), 32'd1);
        chk("byp_data", byp1_data, 32'hCAFE_0009);
        oprs1 = 5'd0;
        #1;
        chk("byp_x0_hit", 32'(byp1_hit), 32'd0);
        chk("byp_x0_data", byp1_data, 32'd0);
`else
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE_0009;
        tick();
        alu_valid = 1'b0;
        oprs1 = 5'd9;
        #1;
        chk("byp_off_hit", 32'(byp1_hit), 32'd0);
        chk("byp_off_data", byp1_data, 32'd0);
        oprs1 = 5'd0;
`endif

        // Reset pulse with two queued loads discards them
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4;
        ld_valid = 1'b1; ld_rd = 5'd11; ld_funct3 = 3'b010; ld_data = 32'h11;
        tick();
        ld_rd = 5'd12;
        tick();
        idle_inputs();
        chk("pre_rst_count", 32'(lq_count), 32'd2);
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_pulse_count", 32'(lq_count), 32'd0);
        chk("rst_pulse_en", 32'(wrt_en), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_en", 32'(wrt_en), 32'd0);
        chk("post_rst_count", 32'(lq_count), 32'd0);

        // Randomized traffic; small rd range forces kills and x0 hits
        for (int i = 0; i < 3000; i++) begin
            alu_valid  = ($urandom_range(0, 99) < 40);
            alu_rd     = 5'($urandom_range(0, 7));
            alu_data   = $urandom;
            ld_valid   = ($urandom_range(0, 99) < 60);
            ld_rd      = 5'($urandom_range(0, 7));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            ld_data    = $urandom;
            oprs1      = 5'($urandom_range(0, 7));
            oprs2      = 5'($urandom_range(0, 7));
            if (i == 1500) begin
                rst = 1'b1;
                model_clear();
            end
            if (i == 1503) rst = 1'b0;
            tick();
        end

        idle_inputs();
        tick();
        tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
